// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op and state encodings are fixed; counter width follows the default operand width.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  localparam int MDU_WIDTH_DEF = 32;
  localparam int MDU_CNT_W     = $clog2(MDU_WIDTH_DEF);

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shift-add multiplier or restoring divider on the
// 2*WIDTH accumulator; {hi half, lo half} = {partial product, multiplier} or {remainder, quotient}.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     m,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   rem_ext_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // Shifted-out remainder bit is kept in rem_ext_s so the trial compare never loses it
  always_comb begin
    sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
    rem_ext_s = acc[2*WIDTH-1:WIDTH-1];
    ge_s      = (rem_ext_s >= {1'b0, m});
    diff_s    = rem_ext_s[WIDTH-1:0] - m;
    acc_next  = acc;
    if (is_div) begin
      if (ge_s) begin
        acc_next = {diff_s, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_ext_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {sum_s, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; signs are re-applied in the FIX cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t         state_r;
  mdu_op_t            op_r;
  mdu_op_t            op_s;
  logic [WIDTH-1:0]   a_r, b_r, m_r, hi_r, lo_r;
  logic [2*WIDTH-1:0] acc_r, acc_next_s, prod_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               res_neg_r, rem_neg_r, busy_r, done_r;
  logic               is_div_s, is_signed_s, a_neg_s, b_neg_s, b_zero_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, quo_s, rem_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1'b1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1'b1);
  endfunction

  // Op decode for the latched operation
  always_comb begin
    op_s        = mdu_op_t'(op);
    is_div_s    = 1'b0;
    is_signed_s = 1'b0;
    case (op_r)
      OP_MULT:  is_signed_s = 1'b1;
      OP_MULTU: is_signed_s = 1'b0;
      OP_DIV: begin
        is_div_s    = 1'b1;
        is_signed_s = 1'b1;
      end
      OP_DIVU:  is_div_s = 1'b1;
      default: begin
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
      end
    endcase
  end

  // Operand magnitudes and final sign-corrected results
  always_comb begin
    a_neg_s  = is_signed_s & a_r[WIDTH-1];
    b_neg_s  = is_signed_s & b_r[WIDTH-1];
    b_zero_s = (b_r == {WIDTH{1'b0}});
    a_mag_s  = a_neg_s ? neg_w(a_r) : a_r;
    b_mag_s  = b_neg_s ? neg_w(b_r) : b_r;
    prod_s   = res_neg_r ? neg_2w(acc_r) : acc_r;
    quo_s    = res_neg_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    rem_s    = rem_neg_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_s),
    .acc      (acc_r),
    .m        (m_r),
    .acc_next (acc_next_s)
  );

  // Control FSM, iteration datapath and HI/LO write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_MULT;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      m_r       <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              case (op_s)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  a_r     <= op1;
                  b_r     <= op2;
                  op_r    <= op_s;
                  state_r <= ST_PREP;
                  busy_r  <= 1'b1;
                end
                OP_MTHI: hi_r <= op1;
                OP_MTLO: lo_r <= op1;
                default: ;
              endcase
            end
          end
          ST_PREP: begin
            m_r       <= is_div_s ? b_mag_s : a_mag_s;
            acc_r     <= {{WIDTH{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
            // A zero divisor keeps the all-ones quotient unnegated
            res_neg_r <= (a_neg_s ^ b_neg_s) & ~(is_div_s & b_zero_s);
            rem_neg_r <= a_neg_s;
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= ST_RUN;
          end
          ST_RUN: begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_W'(1'b1);
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
              state_r <= ST_FIX;
            end
          end
          ST_FIX: begin
            if (is_div_s) begin
              hi_r <= rem_s;
              lo_r <= quo_s;
            end else begin
              hi_r <= prod_s[2*WIDTH-1:WIDTH];
              lo_r <= prod_s[WIDTH-1:0];
            end
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results,
// latency, abort, start-while-busy and asynchronous reset checks.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        abort;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .op1   (op1),
    .op2   (op2),
    .abort (abort),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one arithmetic op and check latency, done pulse and HI/LO
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'd34);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int seen_done;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; op1 = 32'd0; op2 = 32'd0; abort = 1'b0;
    #12;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_zero",  3'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu_zero", 3'd3, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF);

    // MTHI: one-cycle write, never busy
    @(negedge clk);
    start = 1'b1; op = 3'd4; op1 = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);

    // DIVU with a start-while-busy attempt and an abort at cycle 10
    start = 1'b1; op = 3'd3; op1 = 32'd100; op2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd5; op1 = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_lo", 64'(lo), 64'hFFFF_FFFF);
    check("busy_start_busy", 64'(busy), 64'd1);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'h1234);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1;
      @(negedge clk);
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_lo", 64'(lo), 64'hFFFF_FFFF);
    check("abort_hi_late", 64'(hi), 64'h1234);

    run_op("divu_post_abort", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    // Asynchronous reset in the middle of RUN
    start = 1'b1; op = 3'd1; op1 = 32'd3; op2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_run_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
